// File: rtl/edge_detect_array.sv
// Multi-channel edge detector: synchroniser, debounce, edge pulse,
// sticky W1C status and a masked interrupt.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   sig_in              raw asynchronous channel inputs
//   rise_en, fall_en    per-channel edge-mode enables
//   clr                 write-1-to-clear strobes for status
//   irq_en              per-channel interrupt mask
//   level               accepted (synchronised, debounced) level
//   pulse               one-cycle pulse per enabled accepted edge
//   status              sticky edge flags
//   irq                 OR of (status & irq_en)
module edge_detect_array #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] irq_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] status,
    output logic             irq
);

    // DEBOUNCE of 0 or 1 both mean "accept on the first differing cycle"
    localparam int DB = (DEBOUNCE > 1) ? DEBOUNCE : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(DB - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] pulse_d;
    logic [WIDTH-1:0] status_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sig_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Counter runs only while synced disagrees with the accepted level;
    // reaching terminal count accepts the new level and restarts at 0,
    // so the counter can never wrap.
    always_comb begin
        accept  = '0;
        level_d = level;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != level[i]) begin
                if (cnt_q[i] == TC) begin
                    accept[i]  = 1'b1;
                    level_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        pulse_d  = accept & ((synced & rise_en) | (~synced & fall_en));
        // a new pulse wins over a simultaneous clear
        status_d = (status & ~clr) | pulse_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level  <= '0;
            pulse  <= '0;
            status <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level  <= level_d;
            pulse  <= pulse_d;
            status <= status_d;
        end
    end

    assign irq = |(status & irq_en);

endmodule
